// File: rtl/pkt_tx_pkg.sv
// Shared types and default sizing for the packet transmit framer and its bench.
package pkt_tx_pkg;

    localparam int DATA_W         = 8;
    localparam int BUF_DEPTH_DFLT = 32;
    localparam int LEN_DEPTH_DFLT = 4;
    localparam int BUF_PTR_W      = $clog2(BUF_DEPTH_DFLT) + 1;
    localparam int LEN_PTR_W      = $clog2(LEN_DEPTH_DFLT) + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2,
        GAP      = 2'd3
    } tx_state_e;

    // Completion event codes; the bench scoreboard tallies pulses by these.
    typedef enum logic [1:0] {
        EV_NONE     = 2'd0,
        EV_SENT     = 2'd1,
        EV_OVERSIZE = 2'd2,
        EV_DROP     = 2'd3
    } tx_ev_e;

endpackage

// File: rtl/pkt_tx_if.sv
// Payload input stream plus framed output bus, ack and status pulses.
interface pkt_tx_if;
    import pkt_tx_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              bnd_plse;
    logic              ack;
    logic              err_oversize;
    logic              err_drop;
    logic              pkt_sent;

    modport master (
        input  in_data, in_valid, in_last, ack,
        output in_ready, out_data, out_valid, bnd_plse, err_oversize, err_drop, pkt_sent
    );

    modport slave (
        output in_data, in_valid, in_last, ack,
        input  in_ready, out_data, out_valid, bnd_plse, err_oversize, err_drop, pkt_sent
    );

endinterface

// File: rtl/pkt_len_fifo.sv
// Purpose: small synchronous FIFO holding completed packet lengths.
// Latency: a pushed entry is visible at head_dat the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full/empty.
module pkt_len_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head_dat = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push && !full) begin
            wptr_d = wptr_q + (AW+1)'(1);
        end
        if (pop && !empty) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wptr_q[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/pkt_tx_framer.sv
// Purpose: buffer packets, send each as length byte + payload, retry until acked or dropped.
// Latency: frame starts 2 cycles after the in_last byte is accepted when idle.
// Backpressure: in_ready drops when the byte buffer or length queue is full; discard phase always accepts.
module pkt_tx_framer
    import pkt_tx_pkg::*;
#(
    parameter int MAX_PAYLOAD = 16,
    parameter int BUF_DEPTH   = BUF_DEPTH_DFLT,
    parameter int LEN_DEPTH   = LEN_DEPTH_DFLT,
    parameter int ACK_TIMEOUT = 64,
    parameter int MAX_RETRY   = 3,
    parameter int IFG         = 2
) (
    input  logic     clk,
    input  logic     reset,
    pkt_tx_if.master bus
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_PAYLOAD + 2);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int GW = $clog2(IFG + 1);

    localparam logic [PW-1:0] P_ONE = PW'(1);
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [CW-1:0] C_MAX = CW'(MAX_PAYLOAD);
    localparam logic [TW-1:0] T_ONE = TW'(1);
    localparam logic [TW-1:0] T_END = TW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] R_ONE = RW'(1);
    localparam logic [RW-1:0] R_MAX = RW'(MAX_RETRY);
    localparam logic [GW-1:0] G_ONE = GW'(1);
    localparam logic [GW-1:0] G_END = GW'(IFG - 1);

    logic              up_q, discard_q, discard_d;
    logic [PW-1:0]     wptr_q, wptr_d, pkt_start_q, pkt_start_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic              err_oversize_q, oversize;
    logic              buf_full, in_ready, in_fire, wr_en;
    logic              len_push, len_pop, len_full, len_empty;
    logic [DATA_W-1:0] len_head, buf_q [BUF_DEPTH];

    tx_state_e         state_q, state_d;
    tx_ev_e            out_ev;
    logic [DATA_W-1:0] len_q, len_d, rd_dat, out_data;
    logic [PW-1:0]     rd_base_q, rd_base_d, rptr_q, rptr_d;
    logic [CW-1:0]     idx_q, idx_d, len_cnt;
    logic [TW-1:0]     timer_q, timer_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              resend_q, resend_d;
    logic              pkt_sent_q, err_drop_q;
    logic              out_valid, bnd;
    logic [AW-1:0]     rd_idx;

    // Uncommitted bytes of the packet being received count towards occupancy.
    assign buf_full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign in_ready = up_q && (discard_q || (!buf_full && !len_full));
    assign in_fire  = bus.in_valid && in_ready;
    assign cnt_inc  = cnt_q + C_ONE;

    always_comb begin
        wptr_d      = wptr_q;
        pkt_start_d = pkt_start_q;
        cnt_d       = cnt_q;
        discard_d   = discard_q;
        wr_en       = 1'b0;
        len_push    = 1'b0;
        oversize    = 1'b0;
        if (in_fire) begin
            if (discard_q) begin
                discard_d = !bus.in_last;
            end else if (cnt_q == C_MAX) begin
                oversize  = 1'b1;
                wptr_d    = pkt_start_q;
                cnt_d     = '0;
                discard_d = !bus.in_last;
            end else begin
                wr_en  = 1'b1;
                wptr_d = wptr_q + P_ONE;
                cnt_d  = cnt_inc;
                if (bus.in_last) begin
                    len_push    = 1'b1;
                    pkt_start_d = wptr_q + P_ONE;
                    cnt_d       = '0;
                end
            end
        end
    end

    pkt_len_fifo #(
        .DEPTH (LEN_DEPTH),
        .WIDTH (DATA_W)
    ) u_len_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (len_push),
        .push_dat (DATA_W'(cnt_inc)),
        .pop      (len_pop),
        .head_dat (len_head),
        .full     (len_full),
        .empty    (len_empty)
    );

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[wptr_q[AW-1:0]] <= bus.in_data;
        end
    end

    assign len_cnt = CW'(len_q);
    assign rd_idx  = rd_base_q[AW-1:0] + AW'(idx_q) - AW'(1);
    assign rd_dat  = buf_q[rd_idx];

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        rd_base_d = rd_base_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        retry_d   = retry_q;
        gap_d     = gap_q;
        resend_d  = resend_q;
        rptr_d    = rptr_q;
        len_pop   = 1'b0;
        out_ev    = EV_NONE;
        out_valid = 1'b0;
        bnd       = 1'b0;
        out_data  = '0;
        case (state_q)
            IDLE: begin
                if (!len_empty) begin
                    len_d     = len_head;
                    rd_base_d = rptr_q;
                    idx_d     = '0;
                    retry_d   = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = (idx_q == '0) ? len_q : rd_dat;
                bnd       = (idx_q == '0) || (idx_q == len_cnt);
                if (idx_q == len_cnt) begin
                    timer_d = '0;
                    state_d = WAIT_ACK;
                end else begin
                    idx_d = idx_q + C_ONE;
                end
            end
            WAIT_ACK: begin
                // An ack on the expiry cycle wins over the timeout.
                if (bus.ack) begin
                    rptr_d   = rd_base_q + PW'(len_q);
                    len_pop  = 1'b1;
                    out_ev   = EV_SENT;
                    resend_d = 1'b0;
                    gap_d    = '0;
                    state_d  = GAP;
                end else if (timer_q == T_END) begin
                    gap_d   = '0;
                    state_d = GAP;
                    if (retry_q == R_MAX) begin
                        rptr_d   = rd_base_q + PW'(len_q);
                        len_pop  = 1'b1;
                        out_ev   = EV_DROP;
                        resend_d = 1'b0;
                    end else begin
                        retry_d  = retry_q + R_ONE;
                        resend_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + T_ONE;
                end
            end
            GAP: begin
                if (gap_q == G_END) begin
                    idx_d   = '0;
                    state_d = resend_q ? SEND : IDLE;
                end else begin
                    gap_d = gap_q + G_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_q           <= 1'b0;
            wptr_q         <= '0;
            pkt_start_q    <= '0;
            cnt_q          <= '0;
            discard_q      <= 1'b0;
            err_oversize_q <= 1'b0;
        end else begin
            up_q           <= 1'b1;
            wptr_q         <= wptr_d;
            pkt_start_q    <= pkt_start_d;
            cnt_q          <= cnt_d;
            discard_q      <= discard_d;
            err_oversize_q <= oversize;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            rd_base_q  <= '0;
            rptr_q     <= '0;
            idx_q      <= '0;
            timer_q    <= '0;
            retry_q    <= '0;
            gap_q      <= '0;
            resend_q   <= 1'b0;
            pkt_sent_q <= 1'b0;
            err_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rd_base_q  <= rd_base_d;
            rptr_q     <= rptr_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            gap_q      <= gap_d;
            resend_q   <= resend_d;
            pkt_sent_q <= (out_ev == EV_SENT);
            err_drop_q <= (out_ev == EV_DROP);
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_data     = out_data;
    assign bus.out_valid    = out_valid;
    assign bus.bnd_plse     = bnd;
    assign bus.err_oversize = err_oversize_q;
    assign bus.err_drop     = err_drop_q;
    assign bus.pkt_sent     = pkt_sent_q;

endmodule

// File: tb/tb_pkt_tx_framer.sv
// Random-stimulus bench: packets in, frames checked against an expected-packet queue.
module tb_pkt_tx_framer;
    import pkt_tx_pkg::*;

    localparam int MAXP    = 16;
    localparam int ACK_TO  = 64;
    localparam int RETRIES = 3;
    localparam int GAPC    = 2;

    typedef struct packed {
        logic [7:0]        len;
        logic [MAXP*8-1:0] dat;
    } pkt_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pkt_tx_if bus ();
    pkt_tx_framer dut (.clk(clk), .reset(reset), .bus(bus));

    int   n_chk = 0;
    int   n_pass = 0;
    pkt_t exp_q[$];
    int   got_ev [4] = '{default: 0};
    int   frames = 0, cur_n = 0, idle = 1000, ack_cnt = 0, acc_bytes = 0;
    int   exp_pushed = 0, exp_over = 0, exp_drop = 0, exp_lost = 0;
    bit   bnd_bad = 1'b0, retry_pend = 1'b0, ack_en = 1'b0;
    logic [7:0]        cur_len = '0;
    logic [MAXP*8-1:0] cur_dat = '0;

    task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, want);
    endtask

    function automatic logic [159:0] rand_bytes();
        logic [159:0] r;
        for (int i = 0; i < 5; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: a packet of 1..MAXP bytes becomes one frame {len, payload}; longer ones vanish.
    task automatic send_pkt(input int len, input logic [159:0] data);
        pkt_t p;
        bit   ok;
        int   n;
        if (len <= MAXP) begin
            p.len = 8'(len);
            p.dat = '0;
            for (int i = 0; i < len; i++) p.dat[i*8 +: 8] = data[i*8 +: 8];
            exp_q.push_back(p);
            exp_pushed++;
        end else begin
            exp_over++;
        end
        for (int i = 0; i < len; i++) begin
            bus.in_data  = data[i*8 +: 8];
            bus.in_valid = 1'b1;
            bus.in_last  = (i == len - 1);
            n = 0;
            do begin
                ok = bus.in_ready;
                @(posedge clk);
                @(negedge clk);
                n++;
            end while (!ok && n < 2000);
            if (!ok) begin
                chk("in_stall", 136'(ok), 136'(1));
                break;
            end
            acc_bytes++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || cur_n != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 136'(exp_q.size()), 136'(0));
        repeat (4) @(negedge clk);
    endtask

    // Output monitor, frame checker and ack responder.
    initial begin
        bus.ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_lost  += exp_q.size();
                exp_q.delete();
                cur_n      = 0;
                bus.ack    = 1'b0;
                ack_cnt    = 0;
                retry_pend = 1'b0;
                idle       = 1000;
            end else begin
                bus.ack = 1'b0;
                if (ack_cnt > 0) begin
                    ack_cnt--;
                    if (ack_cnt == 0) bus.ack = 1'b1;
                end
                if (bus.pkt_sent) begin
                    got_ev[int'(EV_SENT)]++;
                    retry_pend = 1'b0;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                if (bus.err_drop) begin
                    got_ev[int'(EV_DROP)]++;
                    retry_pend = 1'b0;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                if (bus.err_oversize) got_ev[int'(EV_OVERSIZE)]++;
                if (bus.out_valid) begin
                    if (cur_n == 0) begin
                        chk("ifg_min", 136'(idle >= GAPC), 136'(1));
                        if (retry_pend) chk("retry_gap", 136'(idle), 136'(ACK_TO + GAPC));
                        cur_len = bus.out_data;
                        cur_dat = '0;
                        bnd_bad = (bus.bnd_plse !== 1'b1);
                    end else begin
                        if (cur_n <= MAXP) cur_dat[(cur_n-1)*8 +: 8] = bus.out_data;
                        if (bus.bnd_plse !== (cur_n == int'(cur_len))) bnd_bad = 1'b1;
                    end
                    cur_n++;
                    idle = 0;
                    if (cur_n == int'(cur_len) + 1) begin
                        frames++;
                        chk("frame_expected", 136'(exp_q.size() > 0), 136'(1));
                        if (exp_q.size() > 0) begin
                            chk("frame_len", 136'(cur_len), 136'(exp_q[0].len));
                            chk("frame_dat", 136'(cur_dat), 136'(exp_q[0].dat));
                        end
                        chk("frame_bnd", 136'(bnd_bad), 136'(0));
                        cur_n      = 0;
                        retry_pend = 1'b1;
                        if (ack_en) ack_cnt = 1 + $urandom_range(0, 8);
                    end
                end else begin
                    if (cur_n != 0) begin
                        chk("valid_gap", 136'(cur_n), 136'(0));
                        cur_n = 0;
                    end
                    idle++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

    initial begin
        int  n, f0, d0, o0;
        bit  low_seen;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 136'({bus.in_ready, bus.out_valid, bus.out_data, bus.bnd_plse,
                                   bus.err_oversize, bus.err_drop, bus.pkt_sent}), 136'(0));
        reset = 1'b1;
        #1 chk("rdy_before_edge", 136'(bus.in_ready), 136'(0));
        @(negedge clk);
        chk("rdy_after_edge", 136'(bus.in_ready), 136'(1));

        ack_en = 1'b1;
        send_pkt(4, 160'h44332211);
        drain("drain_sanity");
        chk("sanity_sent", 136'(got_ev[int'(EV_SENT)]), 136'(1));

        send_pkt(16, rand_bytes());
        send_pkt(1, 160'hAA);
        drain("drain_minmax");

        o0 = got_ev[int'(EV_OVERSIZE)];
        send_pkt(17, rand_bytes());
        send_pkt(2, 160'hBBCC);
        drain("drain_oversize");
        chk("oversize_pulse", 136'(got_ev[int'(EV_OVERSIZE)] - o0), 136'(1));

        for (int k = 0; k < 24; k++) send_pkt($urandom_range(1, 20), rand_bytes());
        drain("drain_random");

        ack_en    = 1'b0;
        acc_bytes = 0;
        fork
            begin
                for (int k = 0; k < 5; k++) send_pkt(8, rand_bytes());
            end
        join_none
        low_seen = 1'b0;
        n = 0;
        while (!low_seen && n < 400) begin
            @(negedge clk);
            #1;
            if (!bus.in_ready) low_seen = 1'b1;
            else n++;
        end
        chk("bp_ready_low", 136'(low_seen), 136'(1));
        chk("bp_bytes_at_full", 136'(acc_bytes), 136'(32));
        ack_en = 1'b1;
        wait fork;
        drain("drain_backpressure");

        @(negedge clk);
        ack_en = 1'b0;
        f0 = frames;
        d0 = got_ev[int'(EV_DROP)];
        send_pkt(3, 160'h030201);
        send_pkt(2, 160'h5A5A);
        n = 0;
        while (got_ev[int'(EV_DROP)] == d0 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        ack_en = 1'b1;
        exp_drop++;
        chk("retry_frames", 136'(frames - f0), 136'(RETRIES + 1));
        chk("drop_pulse", 136'(got_ev[int'(EV_DROP)] - d0), 136'(1));
        drain("drain_timeout");

        @(negedge clk);
        f0 = frames;
        send_pkt(6, rand_bytes());
        n = 0;
        while (cur_n != 2 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("mid_frame_reached", 136'(cur_n), 136'(2));
        reset = 1'b0;
        #1 chk("reset_mid_frame", 136'({bus.in_ready, bus.out_valid, bus.out_data, bus.bnd_plse,
                                        bus.err_oversize, bus.err_drop, bus.pkt_sent}), 136'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1 chk("rdy_release", 136'(bus.in_ready), 136'(0));
        @(negedge clk);
        #1 chk("rdy_back", 136'(bus.in_ready), 136'(1));
        repeat (100) @(negedge clk);
        chk("no_stale_frame", 136'(frames), 136'(f0));
        send_pkt(2, 160'hC3D4);
        drain("drain_after_reset");

        chk("sent_total", 136'(got_ev[int'(EV_SENT)]), 136'(exp_pushed - exp_drop - exp_lost));
        chk("oversize_total", 136'(got_ev[int'(EV_OVERSIZE)]), 136'(exp_over));
        chk("drop_total", 136'(got_ev[int'(EV_DROP)]), 136'(exp_drop));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
